alu_result_stage: RTL

ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

---
 rtl/alu_result_stage_pkg.sv | 59 +++++
 rtl/alu_result_stage_buf.sv | 90 +++++++++
 rtl/alu_result_stage.sv | 65 ++++++
 3 files changed

// File: rtl/alu_result_stage_pkg.sv
// Shared ALU types: function codes, committed flag layout, branch conditions,
// and the result-buffer state encoding used when ALU_RESULT_STAGE_SKID_EN is set.
package alu_result_stage_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SHL  = 4'd5,
        ALU_SHR  = 4'd6,
        ALU_PASS = 4'd7
    } alu_func_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    typedef enum logic [2:0] {
        COND_ALWAYS = 3'd0,
        COND_EQ     = 3'd1,
        COND_NE     = 3'd2,
        COND_CS     = 3'd3,
        COND_CC     = 3'd4,
        COND_MI     = 3'd5,
        COND_PL     = 3'd6,
        COND_VS     = 3'd7
    } cond_e;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_e;

    localparam int unsigned FLAG_W = 4;

    function automatic logic cond_eval(input flags_t f, input cond_e sel);
        logic r;
        r = 1'b1;
        case (sel)
            COND_ALWAYS: r = 1'b1;
            COND_EQ:     r = f.z;
            COND_NE:     r = !f.z;
            COND_CS:     r = f.c;
            COND_CC:     r = !f.c;
            COND_MI:     r = f.n;
            COND_PL:     r = !f.n;
            COND_VS:     r = f.v;
            default:     r = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_result_stage_buf.sv
// Result storage with valid/ready handshake. Single register by default;
// a 2-entry skid buffer with registered in_ready when ALU_RESULT_STAGE_SKID_EN is defined.
module alu_result_buf
    import alu_result_stage_pkg::*;
#(
    parameter int unsigned W = 13
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

`ifdef ALU_RESULT_STAGE_SKID_EN
    buf_state_e   r_state;
    buf_state_e   w_state_nxt;
    logic         r_in_ready;
    logic [W-1:0] r_head;
    logic [W-1:0] r_tail;
    logic         w_accept;
    logic         w_drain;

    assign w_accept  = in_valid && r_in_ready;
    assign w_drain   = (r_state != BUF_EMPTY) && out_ready;
    assign in_ready  = r_in_ready;
    assign out_valid = (r_state != BUF_EMPTY);
    assign out_data  = r_head;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            BUF_EMPTY: if (w_accept) w_state_nxt = BUF_ONE;
            BUF_ONE: begin
                if (w_accept && !w_drain)      w_state_nxt = BUF_TWO;
                else if (!w_accept && w_drain) w_state_nxt = BUF_EMPTY;
            end
            BUF_TWO:   if (w_drain) w_state_nxt = BUF_ONE;
            default:   w_state_nxt = BUF_EMPTY;
        endcase
    end

    // in_ready is precomputed from the next state so it stays a flop output
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= BUF_EMPTY;
            r_in_ready <= 1'b1;
            r_head     <= '0;
            r_tail     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != BUF_TWO);
            case (r_state)
                BUF_EMPTY: if (w_accept) r_head <= in_data;
                BUF_ONE: begin
                    if (w_accept && w_drain) r_head <= in_data;
                    else if (w_accept)       r_tail <= in_data;
                end
                BUF_TWO:   if (w_drain) r_head <= r_tail;
                default: ;
            endcase
        end
    end
`else
    logic         r_valid;
    logic [W-1:0] r_data;
    logic         w_accept;

    assign in_ready  = !r_valid || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign out_valid = r_valid;
    assign out_data  = r_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_data  <= in_data;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: buffers results toward writeback and commits {N,Z,C,V} on drain.
// Define ALU_RESULT_STAGE_SKID_EN for the 2-entry skid buffer variant.
module alu_result_stage
    import alu_result_stage_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic              in_signed_overflow,
    input  logic              in_carry_flag,
    input  logic              in_flags_we,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [3:0]        flags,
    input  logic              flags_clear,
    input  logic [2:0]        cond_sel,
    output logic              cond_true
);

    localparam int unsigned ENT_W = DATA_W + FLAG_W + 1;

    logic [ENT_W-1:0] w_in_data;
    logic [ENT_W-1:0] w_out_data;
    flags_t           w_head_flags;
    logic             w_head_we;
    flags_t           r_flags;

    // Entry layout: {result, N, Z, C, V, flags_we}
    assign w_in_data = {in_result, in_result[DATA_W-1], (in_result == '0),
                        in_carry_flag, in_signed_overflow, in_flags_we};

    alu_result_buf #(.W(ENT_W)) u_buf (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (w_in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_out_data)
    );

    assign out_result   = w_out_data[ENT_W-1 -: DATA_W];
    assign w_head_flags = flags_t'(w_out_data[FLAG_W:1]);
    assign w_head_we    = w_out_data[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flags <= '0;
        end else if (flags_clear) begin
            r_flags <= '0;
        end else if (out_valid && out_ready && w_head_we) begin
            r_flags <= w_head_flags;
        end
    end

    assign flags     = r_flags;
    assign cond_true = cond_eval(r_flags, cond_e'(cond_sel));

endmodule
